image_blitter: RTL

Parametrised image-to-framebuffer blitter for the VGA drawing path. On a `start` pulse it walks a selected ROM image in raster order and emits one `plot`/`x`/`y`/`colour` per pixel to the VGA adapter. It positions the image at a programmable origin and compensates for ROM read latency. It also supports transparent-key skipping and abort. It replaces the fixed 160x120, three-screen drawer used for the title, win and game-over screens, and can also blit sprites such as bricks and the paddle.

---
 rtl/image_blitter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/image_blitter.sv
// Raster-order ROM-to-framebuffer blitter: walks a selected image, tracks ROM latency
// with a valid/cx/cy shift pipeline and emits one plot/x/y/colour per pixel.
module image_blitter #(
    parameter int IMG_W    = 160,
    parameter int IMG_H    = 120,
    parameter int ADDR_W   = 15,
    parameter int COLOUR_W = 3,
    parameter int NUM_IMG  = 3,
    parameter int SEL_W    = 2,
    parameter int ROM_LAT  = 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    input  logic                         abort,
    input  logic [SEL_W-1:0]             img_sel,
    input  logic [9:0]                   x_origin,
    input  logic [9:0]                   y_origin,
    input  logic                         transp_en,
    input  logic [COLOUR_W-1:0]          transp_key,
    input  logic [NUM_IMG*COLOUR_W-1:0]  rom_q,
    output logic [ADDR_W-1:0]            rom_addr,
    output logic                         busy,
    output logic                         done,
    output logic                         plot,
    output logic [9:0]                   x,
    output logic [9:0]                   y,
    output logic [COLOUR_W-1:0]          colour
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W*IMG_H-1);
    localparam logic [9:0]        LAST_CX   = 10'(IMG_W-1);
    localparam int                DCW       = $clog2(ROM_LAT+2);
    localparam logic [DCW-1:0]    DRAIN_LAST = DCW'(ROM_LAT);

    state_t state, next_state;

    logic [SEL_W-1:0]    img_sel_l;
    logic [9:0]          x_origin_l, y_origin_l;
    logic                transp_en_l;
    logic [COLOUR_W-1:0] transp_key_l;

    logic [9:0]          cx, cy;
    logic [DCW-1:0]      drain_cnt;
    logic [ROM_LAT-1:0]  vld_pipe;
    logic [9:0]          cx_pipe [ROM_LAT];
    logic [9:0]          cy_pipe [ROM_LAT];

    logic                abort_active;
    logic [COLOUR_W-1:0] rom_colour;

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = RUN;
            RUN:   if (abort) next_state = IDLE;
                   else if (rom_addr == LAST_ADDR) next_state = DRAIN;
            DRAIN: if (abort) next_state = IDLE;
                   else if (drain_cnt == DRAIN_LAST) next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy         = (state == RUN) || (state == DRAIN);
    assign done         = (state == DONE);
    assign abort_active = abort && busy;

    // Out-of-range image selections read as colour 0.
    always_comb begin
        rom_colour = '0;
        for (int k = 0; k < NUM_IMG; k++) begin
            if (img_sel_l == SEL_W'(k)) rom_colour = rom_q[k*COLOUR_W +: COLOUR_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rom_addr     <= '0;
            cx           <= '0;
            cy           <= '0;
            drain_cnt    <= '0;
            vld_pipe     <= '0;
            plot         <= 1'b0;
            x            <= '0;
            y            <= '0;
            colour       <= '0;
            img_sel_l    <= '0;
            x_origin_l   <= '0;
            y_origin_l   <= '0;
            transp_en_l  <= 1'b0;
            transp_key_l <= '0;
        end else begin
            if (state == IDLE && start) begin
                img_sel_l    <= img_sel;
                x_origin_l   <= x_origin;
                y_origin_l   <= y_origin;
                transp_en_l  <= transp_en;
                transp_key_l <= transp_key;
                rom_addr     <= '0;
                cx           <= '0;
                cy           <= '0;
            end

            // Address and column/row counters step together so no divider is needed.
            if (state == RUN && !abort && rom_addr != LAST_ADDR) begin
                rom_addr <= rom_addr + 1'b1;
                if (cx == LAST_CX) begin
                    cx <= '0;
                    cy <= cy + 1'b1;
                end else begin
                    cx <= cx + 1'b1;
                end
            end

            if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
            else                drain_cnt <= '0;

            vld_pipe[0] <= (state == RUN);
            cx_pipe[0]  <= cx;
            cy_pipe[0]  <= cy;
            for (int i = 1; i < ROM_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                cx_pipe[i]  <= cx_pipe[i-1];
                cy_pipe[i]  <= cy_pipe[i-1];
            end
            if (abort_active) vld_pipe <= '0;

            // Keyed pixels still advance x/y/colour but suppress the write strobe.
            if (abort_active) begin
                plot <= 1'b0;
            end else if (vld_pipe[ROM_LAT-1]) begin
                x      <= x_origin_l + cx_pipe[ROM_LAT-1];
                y      <= y_origin_l + cy_pipe[ROM_LAT-1];
                colour <= rom_colour;
                plot   <= !(transp_en_l && (rom_colour == transp_key_l));
            end else begin
                plot <= 1'b0;
            end
        end
    end

endmodule
